gcd_unit: RTL and testbench

Self-contained, parametrised GCD engine: datapath registers, comparator/subtractor and control FSM in one block, with valid/ready handshakes on both sides. Each accepted operand pair uses one of two algorithms, chosen per transaction: subtractive Euclid or binary (Stein). Zero operands are handled directly, and the block reports an iteration count. It sits between an operand producer and a result consumer that may stall.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_step.sv | 55 +++++
 rtl/gcd_unit.sv | 114 +++++++++++
 tb/tb_gcd_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine.
// FSM state encoding and per-transaction algorithm select.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } gcd_state_t;

  typedef enum logic {
    GCD_SUB = 1'b0,
    GCD_BIN = 1'b1
  } gcd_mode_t;

endpackage

// File: rtl/gcd_step.sv
// One GCD reduction step, subtractive or binary.
// Purely combinational; the caller decides when to commit it.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(WIDTH+1)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  input  gcd_mode_t        mode,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] y_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             eq,
  output logic             step_taken
);

  logic [WIDTH-1:0] d_xy;
  logic [WIDTH-1:0] d_yx;
  logic             gt;

  assign d_xy = x - y;
  assign d_yx = y - x;
  assign gt   = x > y;

  always_comb begin
    x_nxt      = x;
    y_nxt      = y;
    k_nxt      = k;
    eq         = (x == y);
    step_taken = (x != y);
    if (!eq) begin
      if (mode == GCD_SUB) begin
        if (gt) x_nxt = d_xy;
        else    y_nxt = d_yx;
      end else begin
        // Arms are mutually exclusive on the operand LSBs.
        unique case (1'b1)
          (!x[0] && !y[0]): begin
            x_nxt = x >> 1;
            y_nxt = y >> 1;
            k_nxt = k + KW'(1);
          end
          (!x[0] && y[0]): x_nxt = x >> 1;
          (x[0] && !y[0]): y_nxt = y >> 1;
          (x[0] && y[0] && gt): x_nxt = d_xy >> 1;
          default: y_nxt = d_yx >> 1;
        endcase
      end
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// GCD engine: handshake FSM, operand registers, iteration counter.
// One gcd_step reduction is committed per cycle in S_REDUCE.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [ITER_W-1:0] iters,
  output logic              busy
);

  localparam int KW = $clog2(WIDTH+1);

  gcd_state_t       state_q;
  gcd_state_t       state_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [KW-1:0]    k_q;
  gcd_mode_t        mode_q;
  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [KW-1:0]    k_nxt;
  logic             eq;
  logic             step_taken;

  gcd_step #(
    .WIDTH(WIDTH),
    .KW   (KW)
  ) u_step (
    .x         (x_q),
    .y         (y_q),
    .k         (k_q),
    .mode      (mode_q),
    .x_nxt     (x_nxt),
    .y_nxt     (y_nxt),
    .k_nxt     (k_nxt),
    .eq        (eq),
    .step_taken(step_taken)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CHECK) ||
                     (state_q == S_REDUCE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (x_q == '0 || y_q == '0) state_d = S_DONE;
        else                        state_d = S_REDUCE;
      end
      S_REDUCE: if (eq) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      k_q    <= '0;
      mode_q <= GCD_SUB;
      iters  <= '0;
      result <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q    <= a_in;
            y_q    <= b_in;
            k_q    <= '0;
            mode_q <= gcd_mode_t'(mode);
            iters  <= '0;
          end
        end
        S_CHECK: begin
          if (x_q == '0)      result <= y_q;
          else if (y_q == '0) result <= x_q;
        end
        S_REDUCE: begin
          if (eq) begin
            result <= x_q << k_q;
          end else if (step_taken) begin
            x_q <= x_nxt;
            y_q <= y_nxt;
            k_q <= k_nxt;
            if (iters != '1) iters <= iters + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboard bench for gcd_unit.
module tb_gcd_unit;

  typedef struct {
    logic [15:0] res;
    logic [15:0] it;
    int          lat;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] iters;
  logic        busy;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_a_in;
  logic [15:0] s_b_in;
  logic        s_mode;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_result;
  logic [3:0]  s_iters;
  logic        s_busy;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16), .ITER_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .iters(iters), .busy(busy)
  );

  gcd_unit #(.WIDTH(16), .ITER_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a_in(s_a_in), .b_in(s_b_in), .mode(s_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .iters(s_iters), .busy(s_busy)
  );

  function automatic logic [15:0] ref_gcd(
    input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input bit m, input exp_t e);
    @(negedge clk);
    a_in = a; b_in = b; mode = m; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         input bit m, input exp_t e, input int budget,
                         output logic [15:0] r, output logic [15:0] it,
                         output int lat, output logic ok);
    issue(a, b, m, e);
    wait_out(budget, lat);
    r = result; it = iters; ok = out_valid;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 ||
        result !== 16'd0 || iters !== 16'd0) begin
      failures++;
      $display("FAIL reset: rdy/vld/busy=%b res=%0d it=%0d want 100/0/0",
               {in_ready, out_valid, busy}, result, iters);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_txn(input string name, input logic [15:0] r,
                           input logic [15:0] it, input int lat,
                           input logic ok);
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: out_valid=%b want 1", name, ok);
    end
    checks++;
    if (r !== e.res) begin
      failures++;
      $display("FAIL %s_result: got %0d want %0d", name, r, e.res);
    end
    if (e.chk) begin
      checks++;
      if (it !== e.it) begin
        failures++;
        $display("FAIL %s_iters: got %0d want %0d", name, it, e.it);
      end
      checks++;
      if (lat != e.lat) begin
        failures++;
        $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat);
      end
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b want 1/0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_sub();
    logic [15:0] r, it; int lat; logic ok;
    run_one(16'd12, 16'd18, 1'b0, '{16'd6, 16'd2, 5, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("sub_12_18", r, it, lat, ok);
    run_one(16'd36, 16'd24, 1'b0, '{16'd12, 16'd2, 5, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("sub_36_24", r, it, lat, ok);
  endtask

  task automatic test_bin();
    logic [15:0] r, it; int lat; logic ok;
    run_one(16'd12, 16'd18, 1'b1, '{16'd6, 16'd3, 6, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("bin_12_18", r, it, lat, ok);
    run_one(16'd9, 16'd9, 1'b1, '{16'd9, 16'd0, 3, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("bin_9_9", r, it, lat, ok);
  endtask

  task automatic test_zero();
    logic [15:0] r, it; int lat; logic ok;
    run_one(16'd0, 16'd35, 1'b0, '{16'd35, 16'd0, 2, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("zero_a", r, it, lat, ok);
    run_one(16'd35, 16'd0, 1'b1, '{16'd35, 16'd0, 2, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("zero_b", r, it, lat, ok);
    run_one(16'd0, 16'd0, 1'b0, '{16'd0, 16'd0, 2, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("zero_both", r, it, lat, ok);
  endtask

  task automatic test_backpressure();
    logic [15:0] r, it; int lat; logic ok;
    exp_t e;
    run_one(16'd36, 16'd24, 1'b0, '{16'd12, 16'd2, 5, 1'b1}, 100,
            r, it, lat, ok);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a_in = 16'd5; b_in = 16'd3; mode = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result !== e.res || iters !== e.it) begin
        failures++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b res=%0d it=%0d want 1/0/%0d/%0d",
                 i, out_valid, in_ready, result, iters, e.res, e.it);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: rdy=%b vld=%b want 1/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_accept: busy=%b rdy=%b want 0/1",
               busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r, it, a, b; int lat; logic ok; bit m;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(1, 500));
      b = 16'($urandom_range(1, 500));
      if (i == 0) begin a = 16'd256; b = 16'd96; end
      m = 1'($urandom_range(0, 1));
      run_one(a, b, m, '{ref_gcd(a, b), 16'd0, 0, 1'b0}, 1200,
              r, it, lat, ok);
      check_txn("b2b", r, it, lat, ok);
    end
  endtask

  task automatic test_saturation();
    int lat;
    @(negedge clk);
    s_a_in = 16'hFFFF; s_b_in = 16'd1; s_mode = 1'b0; s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (s_out_valid !== 1'b1 && lat < 70000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_result !== 16'd1 || s_iters !== 4'd15) begin
      failures++;
      $display("FAIL saturation: vld=%b res=%0d it=%0d want 1/1/15",
               s_out_valid, s_result, s_iters);
    end
    @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [15:0] r, it; int lat; logic ok;
    issue(16'd100, 16'd75, 1'b0, '{16'd25, 16'd0, 0, 1'b0});
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: busy=%b want 1", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 ||
        result !== 16'd0 || iters !== 16'd0) begin
      failures++;
      $display("FAIL abort_reset: rdy/vld/busy=%b res=%0d it=%0d want 100/0/0",
               {in_ready, out_valid, busy}, result, iters);
    end
    @(negedge clk);
    rst = 1'b1;
    run_one(16'd7, 16'd21, 1'b0, '{16'd7, 16'd2, 5, 1'b1}, 100,
            r, it, lat, ok);
    check_txn("after_abort", r, it, lat, ok);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; mode = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_a_in = '0; s_b_in = '0; s_mode = 1'b0;
    test_reset();
    test_sub();
    test_bin();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
